// File: rtl/dp_sram_pkg.sv
// dp_sram_pkg: shared helpers, stage record and latency limits for the dual-port SRAM model
package dp_sram_pkg;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;
  localparam int STG_DATA_MAX = 512;
  localparam int STG_IDX_MAX = 32;
  typedef struct packed {
    logic valid;
    logic [STG_IDX_MAX-1:0] idx;
    logic [STG_DATA_MAX/8-1:0] mask;
    logic [STG_DATA_MAX-1:0] data;
  } stage_t;
  function automatic int lanes(input int data_w);
    return data_w / 8;
  endfunction
  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction
  function automatic bit rd_lat_ok(input int lat);
    return lat >= RD_LAT_MIN && lat <= RD_LAT_MAX;
  endfunction
endpackage

// File: rtl/sram_rd_pipe.sv
// sram_rd_pipe: LAT-deep valid/data delay line with hold, async clear and held output data
module sram_rd_pipe #(
  parameter int W = 32,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic         req_v,
  input  logic [W-1:0] req_d,
  output logic         rvalid,
  output logic [W-1:0] rdata
);
  logic [LAT-1:0] v;
  logic [W-1:0] d [LAT];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
      for (int i = 0; i < LAT; i++) d[i] <= '0;
    end else if (!hold) begin
      v[0] <= req_v;
      if (req_v) d[0] <= req_d;
      for (int i = 1; i < LAT; i++) begin
        v[i] <= v[i-1];
        if (v[i-1]) d[i] <= d[i-1];
      end
    end
  end
  assign rvalid = v[LAT-1];
  assign rdata = d[LAT-1];
endmodule

// File: rtl/dp_sram_model.sv
// dp_sram_model: dual-port SRAM, read-only port A and byte-masked read/write port B
module dp_sram_model
  import dp_sram_pkg::*;
#(
  parameter int    DATA_W    = 32,
  parameter int    DEPTH     = 16384,
  parameter int    ADDR_W    = 16,
  parameter int    RD_LAT    = 1,
  parameter int    RDW_NEW   = 0,
  parameter string INIT_FILE = ""
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hold,
  input  logic                    a_en,
  input  logic [ADDR_W-1:0]       a_addr,
  output logic [DATA_W-1:0]       a_rdata,
  output logic                    a_rvalid,
  input  logic [ADDR_W-1:0]       b_addr,
  input  logic [DATA_W/8-1:0]     b_we,
  input  logic [DATA_W-1:0]       b_wd,
  input  logic [DATA_W/8-1:0]     b_re,
  output logic [DATA_W-1:0]       b_rdata,
  output logic                    b_rvalid,
  output logic                    oor_err
);
  localparam int LANES = lanes(DATA_W);
  localparam int IDX_W = idx_w(DEPTH);
  localparam int OFF_W = $clog2(LANES);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-OFF_W-1:0] a_word, b_word;
  logic [IDX_W-1:0] a_idx, b_idx;
  logic a_acc, b_acc, b_wr, a_oor, b_oor, coll;
  logic [DATA_W-1:0] wmask, rmask, b_old, b_new, a_rd, b_rd;
  logic unused_addr;
  generate
    if (!rd_lat_ok(RD_LAT)) begin : g_bad_lat
      $error("dp_sram_model: RD_LAT must be within 1..4");
    end
  endgenerate
  always_comb begin
    a_word = a_addr[ADDR_W-1:OFF_W];
    b_word = b_addr[ADDR_W-1:OFF_W];
    a_idx = a_word[IDX_W-1:0];
    b_idx = b_word[IDX_W-1:0];
    a_oor = |(a_word >> IDX_W);
    b_oor = |(b_word >> IDX_W);
    a_acc = !hold && a_en;
    b_wr = !hold && |b_we;
    b_acc = !hold && (|b_we || |b_re);
    wmask = '0;
    rmask = '0;
    for (int i = 0; i < LANES; i++) begin
      wmask[8*i+:8] = {8{b_we[i]}};
      rmask[8*i+:8] = {8{b_re[i]}};
    end
    b_old = mem[b_idx];
    b_new = (b_wd & wmask) | (b_old & ~wmask);
    coll = b_wr && a_idx == b_idx;
    a_rd = coll && RDW_NEW != 0 ? b_new : mem[a_idx];
    b_rd = b_new & rmask;
  end
  always_ff @(posedge clk) if (b_wr) mem[b_idx] <= b_new;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) oor_err <= 1'b0;
    else if ((a_acc && a_oor) || (b_acc && b_oor)) oor_err <= 1'b1;
  end
  sram_rd_pipe #(.W(DATA_W), .LAT(RD_LAT)) u_a_pipe (
    .clk(clk), .rst(rst), .hold(hold), .req_v(a_acc), .req_d(a_rd),
    .rvalid(a_rvalid), .rdata(a_rdata)
  );
  sram_rd_pipe #(.W(DATA_W), .LAT(RD_LAT)) u_b_pipe (
    .clk(clk), .rst(rst), .hold(hold), .req_v(b_acc), .req_d(b_rd),
    .rvalid(b_rvalid), .rdata(b_rdata)
  );
  assign unused_addr = ^{a_addr, b_addr};
endmodule

// File: tb/tb_dp_sram_model.sv
// tb_dp_sram_model: random and directed checks of two dp_sram_model configurations against a scoreboard
module tb_dp_sram_model;
  localparam int DEPTH = 256;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;
  logic clk = 1'b0;
  logic rst, hold, a_en;
  logic [15:0] a_addr, b_addr;
  logic [3:0] b_we, b_re;
  logic [31:0] b_wd;
  logic [31:0] a_rdata [2];
  logic [31:0] b_rdata [2];
  logic a_rvalid [2];
  logic b_rvalid [2];
  logic oor_err [2];
  int errs = 0;
  int checks = 0;
  logic [31:0] mem_m [DEPTH];
  logic [31:0] due_map [int];
  logic [31:0] exp_d [4];
  logic exp_v [4];
  logic exp_oor;
  int n = 0;
  always #5 clk = ~clk;
  dp_sram_model #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(16), .RD_LAT(LAT0), .RDW_NEW(0), .INIT_FILE("")) u0 (
    .clk(clk), .rst(rst), .hold(hold), .a_en(a_en), .a_addr(a_addr), .a_rdata(a_rdata[0]),
    .a_rvalid(a_rvalid[0]), .b_addr(b_addr), .b_we(b_we), .b_wd(b_wd), .b_re(b_re),
    .b_rdata(b_rdata[0]), .b_rvalid(b_rvalid[0]), .oor_err(oor_err[0])
  );
  dp_sram_model #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(16), .RD_LAT(LAT1), .RDW_NEW(1), .INIT_FILE("")) u1 (
    .clk(clk), .rst(rst), .hold(hold), .a_en(a_en), .a_addr(a_addr), .a_rdata(a_rdata[1]),
    .a_rvalid(a_rvalid[1]), .b_addr(b_addr), .b_we(b_we), .b_wd(b_wd), .b_re(b_re),
    .b_rdata(b_rdata[1]), .b_rvalid(b_rvalid[1]), .oor_err(oor_err[1])
  );
  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s[u%0d] @%0t: got %h expected %h", nm, inst, $time, act, exp);
    end
  endtask
  task automatic model_reset();
    due_map.delete();
    for (int k = 0; k < 4; k++) begin
      exp_v[k] = 1'b0;
      exp_d[k] = '0;
    end
    exp_oor = 1'b0;
  endtask
  task automatic model_edge();
    int aw, bw, ai, bi, key;
    logic [31:0] old, nw, rm;
    if (hold) return;
    n++;
    aw = int'(a_addr) / 4;
    bw = int'(b_addr) / 4;
    if (a_en && aw >= DEPTH) exp_oor = 1'b1;
    if ((b_we != 0 || b_re != 0) && bw >= DEPTH) exp_oor = 1'b1;
    ai = aw % DEPTH;
    bi = bw % DEPTH;
    old = mem_m[bi];
    nw = old;
    rm = '0;
    for (int l = 0; l < 4; l++) begin
      if (b_we[l]) nw[8*l+:8] = b_wd[8*l+:8];
      if (b_re[l]) rm[8*l+:8] = 8'hFF;
    end
    for (int i = 0; i < 2; i++) begin
      int lat = (i == 0) ? LAT0 : LAT1;
      if (a_en)
        due_map[(n + lat - 1) * 4 + i * 2] = (b_we != 0 && bi == ai) ? ((i == 1) ? nw : old) : mem_m[ai];
      if (b_we != 0 || b_re != 0)
        due_map[(n + lat - 1) * 4 + i * 2 + 1] = nw & rm;
    end
    if (b_we != 0) mem_m[bi] = nw;
    for (int k = 0; k < 4; k++) begin
      key = n * 4 + k;
      exp_v[k] = due_map.exists(key);
      if (exp_v[k]) begin
        exp_d[k] = due_map[key];
        due_map.delete(key);
      end
    end
  endtask
  task automatic cyc(input logic en, input logic [15:0] aa, input logic [15:0] ba, input logic [3:0] we,
                     input logic [31:0] wd, input logic [3:0] re, input logic hd);
    a_en = en;
    a_addr = aa;
    b_addr = ba;
    b_we = we;
    b_wd = wd;
    b_re = re;
    hold = hd;
    @(posedge clk);
    if (!rst) model_edge();
    #1;
  endtask
  task automatic idle(input int cnt);
    for (int k = 0; k < cnt; k++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic pulse_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk("a_rvalid", i, 32'(a_rvalid[i]), 32'(exp_v[i*2]));
        chk("a_rdata", i, a_rdata[i], exp_d[i*2]);
        chk("b_rvalid", i, 32'(b_rvalid[i]), 32'(exp_v[i*2+1]));
        chk("b_rdata", i, b_rdata[i], exp_d[i*2+1]);
        chk("oor_err", i, 32'(oor_err[i]), 32'(exp_oor));
      end
    end
  end
  initial begin
    for (int k = 0; k < DEPTH; k++) mem_m[k] = '0;
    rst = 1'b1;
    {a_en, a_addr, b_addr, b_we, b_wd, b_re, hold} = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_a_rvalid", i, 32'(a_rvalid[i]), 32'h0);
      chk("rst_b_rdata", i, b_rdata[i], 32'h0);
      chk("rst_oor", i, 32'(oor_err[i]), 32'h0);
    end
    rst = 1'b0;
    cyc(0, 0, 16'h0000, 4'hF, 32'h0000_0013, 0, 0);
    cyc(1, 16'h0000, 0, 0, 0, 0, 0);
    chk("lit_a0_valid", 0, 32'(a_rvalid[0]), 32'h1);
    chk("lit_a0_data", 0, a_rdata[0], 32'h0000_0013);
    idle(2);
    chk("lit_a0_lat3", 1, a_rdata[1], 32'h0000_0013);
    cyc(0, 0, 16'h0040, 4'b0101, 32'hAABB_CCDD, 0, 0);
    cyc(0, 0, 16'h0040, 0, 0, 4'hF, 0);
    chk("lit_bmask", 0, b_rdata[0], 32'h00BB_00DD);
    cyc(0, 0, 16'h0004, 4'hF, 32'h1111_1111, 0, 0);
    cyc(0, 0, 16'h0008, 4'hF, 32'h2222_2222, 0, 0);
    idle(3);
    cyc(1, 16'h0000, 0, 0, 0, 0, 0);
    cyc(1, 16'h0004, 0, 0, 0, 0, 0);
    cyc(1, 16'h0008, 0, 0, 0, 0, 0);
    chk("lit_pipe_first", 1, a_rdata[1], 32'h0000_0013);
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("lit_hold_frozen", 1, a_rdata[1], 32'h0000_0013);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("lit_pipe_second", 1, a_rdata[1], 32'h1111_1111);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("lit_pipe_third", 1, a_rdata[1], 32'h2222_2222);
    idle(3);
    cyc(1, 16'h0100, 16'h0100, 4'hF, 32'h1122_3344, 0, 0);
    chk("lit_coll_old", 0, a_rdata[0], 32'h0);
    idle(2);
    chk("lit_coll_new", 1, a_rdata[1], 32'h1122_3344);
    cyc(0, 0, 16'h0400, 4'hF, 32'h0000_0005, 0, 0);
    chk("lit_oor_set", 0, 32'(oor_err[0]), 32'h1);
    idle(2);
    chk("lit_oor_sticky", 1, 32'(oor_err[1]), 32'h1);
    pulse_reset();
    chk("lit_oor_clr", 0, 32'(oor_err[0]), 32'h0);
    cyc(1, 16'h0000, 0, 0, 0, 0, 0);
    chk("lit_wrap_word0", 0, a_rdata[0], 32'h0000_0005);
    idle(3);
    cyc(1, 16'h0004, 0, 0, 0, 0, 0);
    pulse_reset();
    idle(3);
    chk("lit_dropped", 1, 32'(a_rvalid[1]), 32'h0);
    cyc(1, 16'h0008, 0, 0, 0, 0, 0);
    idle(2);
    chk("lit_after_rst_v", 1, 32'(a_rvalid[1]), 32'h1);
    chk("lit_after_rst_d", 1, a_rdata[1], 32'h2222_2222);
    for (int t = 0; t < 800; t++) begin
      logic [15:0] aa, ba;
      aa = ($urandom % 32 == 0) ? 16'($urandom) : 16'((($urandom % 8) << 2) | ($urandom % 4));
      ba = ($urandom % 32 == 0) ? 16'($urandom) : 16'((($urandom % 8) << 2) | ($urandom % 4));
      cyc(1'($urandom), aa, ba, ($urandom % 2) ? 4'($urandom) : 4'h0, $urandom,
          ($urandom % 2) ? 4'($urandom) : 4'h0, ($urandom % 5) == 0);
      if ($urandom % 200 == 0) pulse_reset();
    end
    idle(5);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
